// File: rtl/cmos_tgate_pkg.sv
// Shared 4-state encoding and switch-level helpers for the transmission-gate model.
// Purely combinational definitions; no latency, no flow control.
package cmos_tgate_pkg;

  typedef logic [1:0] lv_t;

  localparam lv_t L0 = 2'b00;
  localparam lv_t L1 = 2'b01;
  localparam lv_t LX = 2'b10;
  localparam lv_t LZ = 2'b11;

  typedef struct packed {
    lv_t source;
    lv_t n_gate;
    lv_t p_gate;
  } tg_in_t;

  // An unknown gate yields X for a driven source: the L/H partial strengths of a
  // real switch are not representable here, so they collapse to X.
  function automatic lv_t nsw(input lv_t s, input lv_t g);
    lv_t r;
    r = LZ;
    case (g)
      L1:      r = s;
      L0:      r = LZ;
      default: r = (s == LZ) ? LZ : LX;
    endcase
    return r;
  endfunction

  function automatic lv_t psw(input lv_t s, input lv_t g);
    lv_t r;
    r = LZ;
    case (g)
      L0:      r = s;
      L1:      r = LZ;
      default: r = (s == LZ) ? LZ : LX;
    endcase
    return r;
  endfunction

  function automatic lv_t resolve(input lv_t a, input lv_t b);
    lv_t r;
    if (a == LZ)      r = b;
    else if (b == LZ) r = a;
    else if (a == b)  r = a;
    else              r = LX;
    return r;
  endfunction

endpackage

// File: rtl/cmos_tgate_lane.sv
// One transmission-gate lane: direct truth table, composed switches, and compare.
// Combinational, zero latency, no backpressure.
module cmos_tgate_lane
  import cmos_tgate_pkg::*;
(
  input  tg_in_t tg_in,
  output lv_t    drain_prim,
  output lv_t    drain_comp,
  output logic   mismatch
);

  logic conduct;
  logic cutoff;

  // Path A is written from raw comparisons so it shares nothing with path B.
  always_comb begin
    conduct = (tg_in.n_gate == 2'b01) || (tg_in.p_gate == 2'b00);
    cutoff  = (tg_in.n_gate == 2'b00) && (tg_in.p_gate == 2'b01);
    if (conduct)
      drain_prim = tg_in.source;
    else if (cutoff)
      drain_prim = 2'b11;
    else
      drain_prim = (tg_in.source == 2'b11) ? 2'b11 : 2'b10;
  end

  assign drain_comp = resolve(nsw(tg_in.source, tg_in.n_gate),
                              psw(tg_in.source, tg_in.p_gate));

  assign mismatch = (drain_prim != drain_comp);

endmodule

// File: rtl/cmos_tgate_model.sv
// Registered two-path CMOS transmission-gate model with per-lane disagreement flags.
// Latency 1 clock; no handshake, outputs update every cycle.
module cmos_tgate_model
  import cmos_tgate_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*LANES-1:0] source,
  input  logic [2*LANES-1:0] n_gate,
  input  logic [2*LANES-1:0] p_gate,
  output logic [2*LANES-1:0] drain_prim,
  output logic [2*LANES-1:0] drain_comp,
  output logic [LANES-1:0]   mismatch,
  output logic               any_mismatch
);

  logic [2*LANES-1:0] prim_d;
  logic [2*LANES-1:0] comp_d;
  logic [LANES-1:0]   mismatch_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tg_in_t lane_in;
    assign lane_in = '{source: source[2*i+:2], n_gate: n_gate[2*i+:2], p_gate: p_gate[2*i+:2]};

    cmos_tgate_lane u_lane (
      .tg_in      (lane_in),
      .drain_prim (prim_d[2*i+:2]),
      .drain_comp (comp_d[2*i+:2]),
      .mismatch   (mismatch_d[i])
    );
  end

  // any_mismatch reduces the same-edge vector so it lines up with mismatch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_prim   <= {LANES{LZ}};
      drain_comp   <= {LANES{LZ}};
      mismatch     <= '0;
      any_mismatch <= 1'b0;
    end else begin
      drain_prim   <= prim_d;
      drain_comp   <= comp_d;
      mismatch     <= mismatch_d;
      any_mismatch <= |mismatch_d;
    end
  end

endmodule

// File: tb/tb_cmos_tgate_model.sv
// Directed bench for cmos_tgate_model with four lanes.
module tb_cmos_tgate_model;

  localparam int LANES = 4;
  localparam logic [1:0] V0 = 2'b00, V1 = 2'b01, VX = 2'b10, VZ = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [2*LANES-1:0] source, n_gate, p_gate;
  logic [2*LANES-1:0] drain_prim, drain_comp;
  logic [LANES-1:0]   mismatch;
  logic               any_mismatch;

  int tests_run = 0;
  int tests_failed = 0;

  cmos_tgate_model #(.LANES(LANES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .source       (source),
    .n_gate       (n_gate),
    .p_gate       (p_gate),
    .drain_prim   (drain_prim),
    .drain_comp   (drain_comp),
    .mismatch     (mismatch),
    .any_mismatch (any_mismatch)
  );

  function automatic logic [7:0] rep(input logic [1:0] v);
    return {4{v}};
  endfunction

  // Reference model: switch with a given conducting gate level, then resolve.
  function automatic logic [1:0] ref_sw(input logic [1:0] s, input logic [1:0] g, input logic on_lvl);
    if (g[1])           return (s == VZ) ? VZ : VX;
    else if (g[0] == on_lvl) return s;
    else                return VZ;
  endfunction

  function automatic logic [1:0] ref_res(input logic [1:0] a, input logic [1:0] b);
    if (a == VZ) return b;
    if (b == VZ) return a;
    if (a == b)  return a;
    return VX;
  endfunction

  function automatic logic [1:0] ref_prim(input logic [1:0] s, input logic [1:0] n, input logic [1:0] p);
    if (n == V1 || p == V0) return s;
    if (n == V0 && p == V1) return VZ;
    return (s == VZ) ? VZ : VX;
  endfunction

  task automatic drive(input logic [1:0] s, input logic [1:0] n, input logic [1:0] p);
    source = rep(s);
    n_gate = rep(n);
    p_gate = rep(p);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      source = 8'($urandom);
      n_gate = 8'($urandom);
      p_gate = 8'($urandom);
      @(posedge clk);
      #1;
      tests_run++;
      if (drain_prim !== 8'hFF || drain_comp !== 8'hFF) begin
        tests_failed++;
        $display("FAIL reset_drains cycle %0d: prim=%h comp=%h expected ff ff", c, drain_prim, drain_comp);
      end
      tests_run++;
      if (mismatch !== 4'b0 || any_mismatch !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_flags cycle %0d: mismatch=%b any=%b expected 0000 0", c, mismatch, any_mismatch);
      end
    end
    rst_n = 1'b1;
  endtask

  // Each entry: {source, n_gate, p_gate, expected drain}
  task automatic run_table(input string name, input logic [7:0] tbl[], input int n);
    for (int i = 0; i < n; i++) begin
      drive(tbl[i][7:6], tbl[i][5:4], tbl[i][3:2]);
      tests_run++;
      if (drain_prim !== rep(tbl[i][1:0])) begin
        tests_failed++;
        $display("FAIL %s_prim[%0d]: got %h expected %h", name, i, drain_prim, rep(tbl[i][1:0]));
      end
      tests_run++;
      if (drain_comp !== rep(tbl[i][1:0])) begin
        tests_failed++;
        $display("FAIL %s_comp[%0d]: got %h expected %h", name, i, drain_comp, rep(tbl[i][1:0]));
      end
      tests_run++;
      if (mismatch !== 4'b0 || any_mismatch !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_flags[%0d]: mismatch=%b any=%b expected 0000 0", name, i, mismatch, any_mismatch);
      end
    end
  endtask

  task automatic test_conducting();
    logic [7:0] tbl[] = '{{V0,V0,V0,V0}, {V1,V0,V0,V1}, {V0,V1,V0,V0},
                          {V1,V1,V0,V1}, {V0,V1,V1,V0}, {V1,V1,V1,V1}};
    run_table("conduct", tbl, 6);
  endtask

  task automatic test_off();
    logic [7:0] tbl[] = '{{V0,V0,V1,VZ}, {V1,V0,V1,VZ}, {VZ,V1,V0,VZ}};
    run_table("off", tbl, 3);
  endtask

  task automatic test_unknown_gates();
    logic [7:0] tbl[] = '{{V1,VX,V1,VX}, {V0,V0,VZ,VX}, {VZ,VX,VX,VZ}};
    run_table("unknown", tbl, 3);
  endtask

  task automatic test_exhaustive();
    for (int k = 0; k < 16; k++) begin
      logic [7:0]  exp_prim, exp_comp;
      logic [3:0]  exp_mm;
      for (int l = 0; l < LANES; l++) begin
        logic [5:0] c;
        c = 6'(k + 16 * l);
        source[2*l+:2] = c[5:4];
        n_gate[2*l+:2] = c[3:2];
        p_gate[2*l+:2] = c[1:0];
        exp_prim[2*l+:2] = ref_prim(c[5:4], c[3:2], c[1:0]);
        exp_comp[2*l+:2] = ref_res(ref_sw(c[5:4], c[3:2], 1'b1), ref_sw(c[5:4], c[1:0], 1'b0));
        exp_mm[l] = (exp_prim[2*l+:2] != exp_comp[2*l+:2]);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (drain_prim !== exp_prim) begin
        tests_failed++;
        $display("FAIL sweep_prim step %0d: got %h expected %h", k, drain_prim, exp_prim);
      end
      tests_run++;
      if (drain_comp !== exp_comp) begin
        tests_failed++;
        $display("FAIL sweep_comp step %0d: got %h expected %h", k, drain_comp, exp_comp);
      end
      tests_run++;
      if (mismatch !== exp_mm || any_mismatch !== (|exp_mm)) begin
        tests_failed++;
        $display("FAIL sweep_flags step %0d: mismatch=%b any=%b expected %b %b", k, mismatch, any_mismatch, exp_mm, |exp_mm);
      end
    end
  endtask

  task automatic test_midstream_reset();
    drive(V1, V1, V0);
    tests_run++;
    if (drain_prim !== rep(V1) || drain_comp !== rep(V1)) begin
      tests_failed++;
      $display("FAIL midreset_before: prim=%h comp=%h expected 55 55", drain_prim, drain_comp);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (drain_prim !== 8'hFF || drain_comp !== 8'hFF || mismatch !== 4'b0 || any_mismatch !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_during: prim=%h comp=%h mm=%b any=%b expected ff ff 0000 0",
               drain_prim, drain_comp, mismatch, any_mismatch);
    end
    rst_n = 1'b1;
    drive(V0, V1, V0);
    tests_run++;
    if (drain_prim !== rep(V0) || drain_comp !== rep(V0)) begin
      tests_failed++;
      $display("FAIL midreset_after: prim=%h comp=%h expected 00 00", drain_prim, drain_comp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    source = '0;
    n_gate = '0;
    p_gate = '0;
    test_reset();
    test_conducting();
    test_off();
    test_unknown_gates();
    test_exhaustive();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
